// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: host loads a byte, arms it into the shift register,
// then starts the frame. Line idles high and bits leave LSB first.
module uart_tx_unit #(
    parameter int WORD_SIZE = 8,
    parameter int BAUD_DIV  = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [WORD_SIZE-1:0] data_bus,
    input  logic                 load_xmt_datareg,
    input  logic                 byte_ready,
    input  logic                 t_byte,
    output logic                 serial_out
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(WORD_SIZE + 2);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SENDING = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] data_reg;
    logic [WORD_SIZE:0]   shift_q, shift_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;

    // Data register is independent of the FSM so a reload never disturbs a frame.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_reg <= '0;
        end else if (load_xmt_datareg) begin
            data_reg <= data_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (byte_ready) begin
                    shift_d = {data_reg, 1'b1};
                    state_d = WAITING;
                end
            end
            WAITING: begin
                if (t_byte) begin
                    shift_d[0] = 1'b0;
                    baud_d     = '0;
                    bit_d      = '0;
                    state_d    = SENDING;
                end else if (byte_ready) begin
                    shift_d = {data_reg, 1'b1};
                end
            end
            SENDING: begin
                // Once the stop bit has been shifted in, its final baud period ends the frame.
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = {1'b1, shift_q[WORD_SIZE:1]};
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign serial_out = shift_q[0];

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit with BAUD_DIV=4, using a frame-level
// reference model of the serial line.
module tb_uart_tx_unit;

    localparam int W     = 8;
    localparam int B     = 4;
    localparam int FRAME = (W + 2) * B;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [W-1:0] data_bus;
    logic         load_xmt_datareg;
    logic         byte_ready;
    logic         t_byte;
    logic         serial_out;

    int checks = 0;
    int errors = 0;

    uart_tx_unit #(.WORD_SIZE(W), .BAUD_DIV(B)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .data_bus         (data_bus),
        .load_xmt_datareg (load_xmt_datareg),
        .byte_ready       (byte_ready),
        .t_byte           (t_byte),
        .serial_out       (serial_out)
    );

    always #5 clk = ~clk;

    // Line level idx cycles after the start edge: start bit, data LSB first, stop bit.
    function automatic logic frame_bit(input logic [W-1:0] d, input int idx);
        int slot;
        slot = idx / B;
        if (slot == 0) return 1'b0;
        if (slot <= W) return d[slot-1];
        return 1'b1;
    endfunction

    // Drive strobes for one clock edge, then settle at the following negedge.
    task automatic step(input logic ld, input logic [W-1:0] d, input logic br, input logic st);
        load_xmt_datareg = ld;
        data_bus         = d;
        byte_ready       = br;
        t_byte           = st;
        @(posedge clk);
        @(negedge clk);
        load_xmt_datareg = 1'b0;
        byte_ready       = 1'b0;
        t_byte           = 1'b0;
    endtask

    task automatic test_reset;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_level: serial_out=%b expected 1", serial_out);
        end
        rst_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (serial_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: serial_out=%b expected 1", i, serial_out);
            end
        end
    endtask

    task automatic test_full_frame;
        logic [W-1:0] d;
        d = 8'hA7;
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL full_pre_start: serial_out=%b expected 1", serial_out);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
            checks++;
            if (serial_out !== frame_bit(d, i)) begin
                errors++;
                $display("FAIL full_frame idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d, i));
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (serial_out !== 1'b1) begin
                errors++;
                $display("FAIL full_post_idle %0d: serial_out=%b expected 1", i, serial_out);
            end
        end
    endtask

    task automatic test_ordering;
        logic [W-1:0] d1, d2;
        d1 = W'($urandom);
        d2 = d1 ^ W'($urandom_range(1, 255));
        step(1'b1, d1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (serial_out !== 1'b1) begin
                errors++;
                $display("FAIL order_tbyte_first %0d: serial_out=%b expected 1", i, serial_out);
            end
        end
        // Arm d1, then reload and re-arm with d2 while waiting: d2 must go out.
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, d2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
            checks++;
            if (serial_out !== frame_bit(d2, i)) begin
                errors++;
                $display("FAIL order_rearm idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d2, i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_load_arm_collision;
        logic [W-1:0] d1, d2;
        d1 = W'($urandom);
        d2 = d1 ^ W'($urandom_range(1, 255));
        step(1'b1, d1, 1'b0, 1'b0);
        step(1'b1, d2, 1'b1, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
            checks++;
            if (serial_out !== frame_bit(d1, i)) begin
                errors++;
                $display("FAIL collide_old idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d1, i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
            checks++;
            if (serial_out !== frame_bit(d2, i)) begin
                errors++;
                $display("FAIL collide_new idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d2, i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_frame;
        logic [W-1:0] d1, d2;
        d1 = 8'hA7;
        d2 = 8'h3C;
        step(1'b1, d1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step((i == 8), (i == 8) ? d2 : 8'h00, (i == 14) || (i == 26), (i == 0) || (i == 20) || (i == 26));
            checks++;
            if (serial_out !== frame_bit(d1, i)) begin
                errors++;
                $display("FAIL mid_frame idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d1, i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_end: serial_out=%b expected 1", serial_out);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
            checks++;
            if (serial_out !== frame_bit(d2, i)) begin
                errors++;
                $display("FAIL mid_next_frame idx %0d: serial_out=%b expected %b", i, serial_out, frame_bit(d2, i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset;
        logic [W-1:0] d;
        d = 8'hA7;
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i <= 17; i++) begin
            step(1'b0, '0, 1'b0, (i == 0));
        end
        checks++;
        if (serial_out !== frame_bit(d, 17)) begin
            errors++;
            $display("FAIL areset_pre: serial_out=%b expected %b", serial_out, frame_bit(d, 17));
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: serial_out=%b expected 1", serial_out);
        end
        @(negedge clk);
        rst_b = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (serial_out !== 1'b1) begin
                errors++;
                $display("FAIL areset_tbyte_ignored %0d: serial_out=%b expected 1", i, serial_out);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] bytes [3];
        for (int f = 0; f < 3; f++) bytes[f] = W'($urandom);
        step(1'b1, bytes[0], 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                step((i == 5) && (f < 2), (f < 2) ? bytes[(f < 2) ? f + 1 : f] : 8'h00, 1'b0, (i == 0));
                checks++;
                if (serial_out !== frame_bit(bytes[f], i)) begin
                    errors++;
                    $display("FAIL b2b frame %0d idx %0d: serial_out=%b expected %b", f, i, serial_out, frame_bit(bytes[f], i));
                end
            end
            // Frame ends on this edge; the arm strobe follows in the next cycle.
            step(1'b0, '0, 1'b0, 1'b0);
            step(1'b0, '0, (f < 2), 1'b0);
            checks++;
            if (serial_out !== 1'b1) begin
                errors++;
                $display("FAIL b2b gap %0d: serial_out=%b expected 1", f, serial_out);
            end
        end
    endtask

    initial begin
        rst_b            = 1'b0;
        data_bus         = '0;
        load_xmt_datareg = 1'b0;
        byte_ready       = 1'b0;
        t_byte           = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_ordering();
        test_load_arm_collision();
        test_mid_frame();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
Name:
uart_tx_unit

Overview:
- Serial UART transmitter: 8N1 framing, LSB first, line idles high.
- A host loads a byte from the shared data bus into an internal transmit data register. It then copies that byte into a transmit shift register and commands transmission.
- Sits between the processor data bus and the off-chip serial line.
- Three separate host strobes give explicit control of load, arm and start.

Parameters:
- WORD_SIZE, 8, data bits per frame; the bench uses 8 only.
- BAUD_DIV, 16, clk cycles per serial bit; legal values are 2 and above.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- data_bus  input  WORD_SIZE  byte to transmit; sampled when load_xmt_datareg=1.
- load_xmt_datareg  input  1  strobe: data_bus -> transmit data register.
- byte_ready  input  1  strobe: transmit data register -> shift register (arm).
- t_byte  input  1  strobe: begin the frame.
- serial_out  output  1  serial line; 1 = idle/mark.

Behaviour:
- Reset (rst_b=0, asynchronous, active-low):
  - state=IDLE; data register=0; shift register all ones; baud and bit counters=0; serial_out=1.
  - Reset mid-frame aborts the frame immediately; the line returns high in the same cycle.
- serial_out is always bit 0 of the shift register, registered and glitch-free.
- Shift register width is WORD_SIZE+1.
- Data register: load_xmt_datareg=1 at an edge captures data_bus. This works in any state and never disturbs a frame in progress.
- States: IDLE, WAITING, SENDING.
- IDLE:
  - byte_ready=1 -> shift register <= {data_reg, 1'b1}; go to WAITING. The line stays high.
  - t_byte alone is ignored.
- WAITING:
  - t_byte=1 -> shift register bit 0 <= 0 (start bit); baud counter=0; bit counter=0; go to SENDING.
  - byte_ready=1 without t_byte re-arms with the current data_reg and stays in WAITING.
  - If both are asserted, t_byte wins.
- SENDING:
  - The baud counter counts 0..BAUD_DIV-1.
  - At terminal count: shift register shifts right with 1 filled into the MSB; bit counter increments.
  - After WORD_SIZE+1 shifts, the line carries the stop bit (1). The stop bit is held for BAUD_DIV cycles, then the block returns to IDLE.
  - byte_ready and t_byte are ignored during SENDING.
- Frame timing:
  - serial_out goes to 0 on the edge that samples t_byte in WAITING.
  - Each of the start bit, WORD_SIZE data bits (LSB first) and the stop bit lasts exactly BAUD_DIV cycles.
  - Total is (WORD_SIZE+2)*BAUD_DIV cycles. IDLE is re-entered at the end of the stop bit.
  - A new frame may be armed and started the next cycle: byte_ready, then t_byte.
- Simultaneous load_xmt_datareg and byte_ready: the shift register receives the OLD data_reg value, and data_reg takes the new data_bus.
- Inputs X before first assertion: the design resets them to benign behaviour by sampling only on the strobe levels listed above. The bench drives all strobes to 0 after reset.

Test Plan:
- Reset: rst_b=0 for 2 cycles -> serial_out=1; with no strobes, serial_out stays 1 for 100 cycles after release.
- Full frame, BAUD_DIV=4, data_bus=0xA7: pulse load_xmt_datareg, then byte_ready, then t_byte, one cycle each, with idle cycles between.
  - Required: serial_out stays 1 until t_byte.
  - Then, each bit held 4 cycles: 0,1,1,1,0,0,1,0,1, then stop bit 1.
  - Then idle high; 40 cycles total.
- Ordering: t_byte before byte_ready -> no frame, line stays 1. byte_ready then t_byte -> frame starts.
- Mid-frame stimulus: during SENDING, pulse load_xmt_datareg with 0x3C and pulse byte_ready/t_byte -> the current 0xA7 frame is unchanged. The next arm+start sends 0x3C: 0,0,0,1,1,1,1,0,0,1.
- Asynchronous reset mid-frame: assert rst_b=0 between clock edges during a data bit -> serial_out=1 immediately and state is IDLE. t_byte alone afterwards does nothing.
- Back-to-back: byte_ready and t_byte on the first cycles after the stop bit -> second frame start bit with no extra idle gap beyond the arm cycle.
